// File: rtl/stopwatch_counter.sv
// Stopwatch time base: minutes/seconds counter with run/pause toggle and a
// 2 Hz field-adjust mode, driven by one-cycle enable ticks from the divider.
module stopwatch_counter #(
    parameter int W       = 6,
    parameter int MAX_SEC = 59,
    parameter int MAX_MIN = 59
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_1hz,
    input  logic         tick_2hz,
    input  logic         pause,
    input  logic         adj,
    input  logic         sel,
    output logic [W-1:0] minutes,
    output logic [W-1:0] seconds,
    output logic         running,
    output logic         adjusting,
    output logic         rollover
);

    typedef enum logic [1:0] {RUN, PAUSED, ADJUST} state_t;

    localparam logic [W-1:0] SEC_LAST = W'(MAX_SEC);
    localparam logic [W-1:0] MIN_LAST = W'(MAX_MIN);
    localparam logic [W-1:0] ONE      = W'(1);

    state_t       state, state_nxt;
    state_t       saved, saved_nxt;
    logic         pause_q;
    logic         pause_edge;
    logic [W-1:0] min_nxt, sec_nxt;
    logic         rollover_nxt;

    always_comb begin
        pause_edge = pause & ~pause_q;

        // The saved mode follows every pause edge, so leaving ADJUST restores
        // whatever run/pause choice was made while adjusting.
        saved_nxt = saved;
        if (pause_edge)
            saved_nxt = (saved == RUN) ? PAUSED : RUN;

        state_nxt = state;
        unique case (state)
            RUN:     if (adj) state_nxt = ADJUST;
                     else if (pause_edge) state_nxt = PAUSED;
            PAUSED:  if (adj) state_nxt = ADJUST;
                     else if (pause_edge) state_nxt = RUN;
            ADJUST:  if (!adj) state_nxt = saved_nxt;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        min_nxt      = minutes;
        sec_nxt      = seconds;
        rollover_nxt = 1'b0;
        // adj gates counting immediately, before the state has moved to ADJUST.
        if (state == RUN && !adj && tick_1hz) begin
            if (seconds < SEC_LAST) begin
                sec_nxt = seconds + ONE;
            end else begin
                sec_nxt = '0;
                if (minutes < MIN_LAST) begin
                    min_nxt = minutes + ONE;
                end else begin
                    min_nxt      = '0;
                    rollover_nxt = 1'b1;
                end
            end
        end else if (state == ADJUST && tick_2hz) begin
            if (sel)
                sec_nxt = (seconds < SEC_LAST) ? seconds + ONE : '0;
            else
                min_nxt = (minutes < MIN_LAST) ? minutes + ONE : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            saved    <= RUN;
            pause_q  <= 1'b1;
            minutes  <= '0;
            seconds  <= '0;
            rollover <= 1'b0;
        end else begin
            state    <= state_nxt;
            saved    <= saved_nxt;
            pause_q  <= pause;
            minutes  <= min_nxt;
            seconds  <= sec_nxt;
            rollover <= rollover_nxt;
        end
    end

    assign running   = (state == RUN);
    assign adjusting = (state == ADJUST);

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed scenarios plus random stimulus, all
// checked every cycle against a time-in-seconds reference model.
module tb_stopwatch_counter;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst, tick_1hz, tick_2hz, pause, adj, sel;
    logic [W-1:0] minutes, seconds;
    logic         running, adjusting, rollover;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0=run 1=paused 2=adjust; count kept as minutes/seconds ints.
    int m_min, m_sec, m_mode, m_saved, m_pq, m_ro;

    stopwatch_counter #(.W(W), .MAX_SEC(59), .MAX_MIN(59)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .pause(pause), .adj(adj), .sel(sel),
        .minutes(minutes), .seconds(seconds),
        .running(running), .adjusting(adjusting), .rollover(rollover)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int total;
        int edge_seen;
        if (rst) begin
            m_min = 0; m_sec = 0; m_mode = 0; m_saved = 0; m_pq = 1; m_ro = 0;
            return;
        end
        edge_seen = (pause && !m_pq) ? 1 : 0;
        m_ro = 0;
        if (m_mode == 0 && !adj && tick_1hz) begin
            total = m_min * 60 + m_sec;
            if (total == 3599) m_ro = 1;
            total = (total + 1) % 3600;
            m_min = total / 60;
            m_sec = total % 60;
        end else if (m_mode == 2 && tick_2hz) begin
            if (sel) m_sec = (m_sec + 1) % 60;
            else     m_min = (m_min + 1) % 60;
        end
        if (edge_seen) m_saved = 1 - m_saved;
        if (m_mode == 2) begin
            if (!adj) m_mode = m_saved;
        end else if (adj) begin
            m_mode = 2;
        end else if (edge_seen) begin
            m_mode = 1 - m_mode;
        end
        m_pq = pause ? 1 : 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("minutes",   int'(minutes),   m_min);
        check("seconds",   int'(seconds),   m_sec);
        check("running",   int'(running),   (m_mode == 0) ? 1 : 0);
        check("adjusting", int'(adjusting), (m_mode == 2) ? 1 : 0);
        check("rollover",  int'(rollover),  m_ro);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_1hz(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    task automatic pulse_2hz(input int n);
        for (int i = 0; i < n; i++) begin
            tick_2hz = 1'b1; step(); tick_2hz = 1'b0;
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    task automatic press_pause();
        pause = 1'b1; step(); pause = 1'b0; step();
    endtask

    initial begin
        rst = 1'b1; tick_1hz = 1'b0; tick_2hz = 1'b0; pause = 1'b0; adj = 1'b0; sel = 1'b0;
        m_min = 0; m_sec = 0; m_mode = 0; m_saved = 0; m_pq = 1; m_ro = 0;
        idle(2);
        check("rst_min", int'(minutes), 0);
        check("rst_run", int'(running), 1);
        check("rst_adj", int'(adjusting), 0);
        rst = 1'b0;
        step();

        // 65 seconds of counting
        pulse_1hz(65);
        check("t1_min", int'(minutes), 1);
        check("t1_sec", int'(seconds), 5);
        check("t1_run", int'(running), 1);

        // preload 59:58 by adjusting, then roll over
        adj = 1'b1; step();
        sel = 1'b0; pulse_2hz((59 - m_min + 60) % 60);
        sel = 1'b1; pulse_2hz((58 - m_sec + 60) % 60);
        check("t2_pre_min", int'(minutes), 59);
        check("t2_pre_sec", int'(seconds), 58);
        adj = 1'b0; step();
        pulse_1hz(1);
        tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
        check("t2_roll", int'(rollover), 1);
        check("t2_min0", int'(minutes), 0);
        check("t2_sec0", int'(seconds), 0);
        step();
        check("t2_roll_end", int'(rollover), 0);

        // pause freezes, second press resumes
        press_pause();
        check("t3_paused", int'(running), 0);
        pulse_1hz(10);
        check("t3_frozen", int'(seconds), 0);
        press_pause();
        check("t3_resume", int'(running), 1);
        pulse_1hz(3);
        check("t3_count", int'(seconds), 3);

        // adjust wraps without carry
        adj = 1'b1; step();
        sel = 1'b1; pulse_2hz(56);
        check("t4_sec59", int'(seconds), 59);
        pulse_2hz(1);
        check("t4_sec_wrap", int'(seconds), 0);
        check("t4_no_carry", int'(minutes), 0);
        sel = 1'b0; pulse_2hz(59);
        pulse_2hz(1);
        check("t4_min_wrap", int'(minutes), 0);
        adj = 1'b0; step();

        // pause toggled while adjusting restores RUN; tick with adj rising ignored
        press_pause();
        adj = 1'b1; step();
        press_pause();
        adj = 1'b0; step();
        check("t5_run", int'(running), 1);
        adj = 1'b1; tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
        check("t5_no_count", int'(seconds), 0);
        adj = 1'b0; idle(2);

        // tick and pause edge in one RUN cycle
        pause = 1'b1; tick_1hz = 1'b1; step(); tick_1hz = 1'b0; pause = 1'b0;
        check("t5b_sec", int'(seconds), 1);
        check("t5b_paused", int'(running), 0);
        press_pause();

        // reset in ADJUST with ticks, pause held through release
        adj = 1'b1; step();
        sel = 1'b1; pulse_2hz(3);
        pause = 1'b1; rst = 1'b1; tick_1hz = 1'b1; tick_2hz = 1'b1;
        step();
        check("t6_sec", int'(seconds), 0);
        check("t6_adj", int'(adjusting), 0);
        check("t6_run", int'(running), 1);
        rst = 1'b0; adj = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0;
        idle(3);
        check("t6_no_toggle", int'(running), 1);
        pause = 1'b0; step();

        // random phase
        for (int i = 0; i < 4000; i++) begin
            tick_1hz = ($urandom_range(0, 3) == 0);
            tick_2hz = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) pause = ~pause;
            if ($urandom_range(0, 39) == 0) adj = ~adj;
            sel = $urandom_range(0, 1) == 1;
            rst = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
